// File: rtl/pair_match_ctrl.sv
// Turn controller for the memory-pair board: pick capture, reveal hold, match/miss resolve, scoring.
// Optional idle-turn forfeit is compiled in when TURN_TIMEOUT_EN is defined.
module pair_match_ctrl #(
  parameter int N_TILES     = 16,
  parameter int IDX_W       = 4,
  parameter int LABEL_W     = 4,
  parameter int SCORE_W     = 4,
  parameter int SHOW_CYCLES = 25,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic [LABEL_W-1:0] sel_label,
  output logic [N_TILES-1:0] par_mask,
  output logic               player,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               match_p,
  output logic               miss_p,
  output logic               timeout_p,
  output logic               game_over,
  output logic [1:0]         winner
);
  localparam int N_PAIRS = N_TILES / 2;
  localparam int PAIR_W  = $clog2(N_PAIRS + 1);
  localparam int SHOW_W  = $clog2(SHOW_CYCLES + 1);

  typedef enum logic [1:0] {WAIT1, WAIT2, SHOW, DONE} state_e;

  state_e             state_q, state_d;
  logic [N_TILES-1:0] matched_q, matched_d;
  logic [N_TILES-1:0] pend_q, pend_d;
  logic [N_TILES-1:0] par_q, par_d;
  logic [LABEL_W-1:0] lbl1_q, lbl1_d, lbl2_q, lbl2_d;
  logic [SHOW_W-1:0]  show_q, show_d;
  logic [PAIR_W-1:0]  pairs_q, pairs_d;
  logic               player_q, player_d;
  logic [SCORE_W-1:0] s0_q, s0_d, s1_q, s1_d;
  logic               match_q, match_d, miss_q, miss_d, tmo_q, tmo_d;

  logic [N_TILES-1:0] sel_oh;
  logic               waiting, pick_ok, idle_expired;

  // Out-of-range indices shift the one-hot to zero, which rejects them for free.
  assign sel_oh  = {{(N_TILES-1){1'b0}}, 1'b1} << sel_idx;
  assign waiting = (state_q == WAIT1) || (state_q == WAIT2);
  // par_q holds matched tiles plus the pending first pick, both of which are illegal picks.
  assign pick_ok = sel_valid && waiting && (sel_oh != '0) && ((sel_oh & par_q) == '0);

`ifdef TURN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign idle_expired = waiting && !pick_ok && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = '0;
    if (waiting && !pick_ok && !idle_expired) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`else
  assign idle_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    matched_d = matched_q;
    pend_d    = pend_q;
    lbl1_d    = lbl1_q;
    lbl2_d    = lbl2_q;
    show_d    = show_q;
    pairs_d   = pairs_q;
    player_d  = player_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    match_d   = 1'b0;
    miss_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      WAIT1: begin
        if (pick_ok) begin
          pend_d  = sel_oh;
          lbl1_d  = sel_label;
          state_d = WAIT2;
        end else if (idle_expired) begin
          player_d = ~player_q;
          tmo_d    = 1'b1;
        end
      end
      WAIT2: begin
        if (pick_ok) begin
          pend_d  = pend_q | sel_oh;
          lbl2_d  = sel_label;
          show_d  = '0;
          state_d = SHOW;
        end else if (idle_expired) begin
          pend_d   = '0;
          player_d = ~player_q;
          tmo_d    = 1'b1;
          state_d  = WAIT1;
        end
      end
      SHOW: begin
        if (show_q == SHOW_W'(SHOW_CYCLES - 1)) begin
          pend_d = '0;
          if (lbl1_q == lbl2_q) begin
            matched_d = matched_q | pend_q;
            pairs_d   = pairs_q + 1'b1;
            match_d   = 1'b1;
            if (player_q) s1_d = (&s1_q) ? s1_q : s1_q + 1'b1;
            else          s0_d = (&s0_q) ? s0_q : s0_q + 1'b1;
            state_d = (pairs_q == PAIR_W'(N_PAIRS - 1)) ? DONE : WAIT1;
          end else begin
            player_d = ~player_q;
            miss_d   = 1'b1;
            state_d  = WAIT1;
          end
        end else begin
          show_d = show_q + 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = WAIT1;
    endcase
    par_d = matched_d | pend_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT1;
      matched_q <= '0;
      pend_q    <= '0;
      par_q     <= '0;
      lbl1_q    <= '0;
      lbl2_q    <= '0;
      show_q    <= '0;
      pairs_q   <= '0;
      player_q  <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      match_q   <= 1'b0;
      miss_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      matched_q <= matched_d;
      pend_q    <= pend_d;
      par_q     <= par_d;
      lbl1_q    <= lbl1_d;
      lbl2_q    <= lbl2_d;
      show_q    <= show_d;
      pairs_q   <= pairs_d;
      player_q  <= player_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      tmo_q     <= tmo_d;
    end
  end

  assign par_mask  = par_q;
  assign player    = player_q;
  assign score0    = s0_q;
  assign score1    = s1_q;
  assign match_p   = match_q;
  assign miss_p    = miss_q;
  assign timeout_p = tmo_q;
  assign game_over = (state_q == DONE);

  always_comb begin
    winner = 2'b00;
    if (state_q == DONE) begin
      if (s0_q > s1_q)      winner = 2'b01;
      else if (s1_q > s0_q) winner = 2'b10;
      else                  winner = 2'b11;
    end
  end

endmodule

// File: tb/tb_pair_match_ctrl.sv
// Directed bench for pair_match_ctrl: vector table for single-turn behaviour plus
// hand-written sequences for full games, mid-SHOW reset and the idle timeout.
module tb_pair_match_ctrl;
  logic        clk, rst, sel_valid;
  logic [4:0]  sel_idx;
  logic [3:0]  sel_label;
  logic [15:0] par_mask;
  logic        player, match_p, miss_p, timeout_p, game_over;
  logic [3:0]  score0, score1;
  logic [1:0]  winner;

  int n_chk = 0;
  int n_fail = 0;

  pair_match_ctrl #(
    .N_TILES(16), .IDX_W(5), .LABEL_W(4), .SCORE_W(4), .SHOW_CYCLES(4), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_label(sel_label),
    .par_mask(par_mask), .player(player), .score0(score0), .score1(score1),
    .match_p(match_p), .miss_p(miss_p), .timeout_p(timeout_p),
    .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  idx;
    logic [3:0]  lbl;
    logic [15:0] par;
    logic        pl;
    logic [3:0]  s0, s1;
    logic        m, ms;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] status();
    return {1'b0, par_mask, player, score0, score1, match_p, miss_p, timeout_p, game_over, winner};
  endfunction

  function automatic logic [31:0] mkst(logic [15:0] par, logic pl, logic [3:0] s0, logic [3:0] s1,
                                       logic m, logic ms, logic tmo, logic go, logic [1:0] win);
    return {1'b0, par, pl, s0, s1, m, ms, tmo, go, win};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] idx, input logic [3:0] lbl,
                     input logic [15:0] par, input logic pl, input logic [3:0] s0,
                     input logic [3:0] s1, input logic m, input logic ms);
    vec_t r;
    r.v = v; r.idx = idx; r.lbl = lbl; r.par = par; r.pl = pl;
    r.s0 = s0; r.s1 = s1; r.m = m; r.ms = ms;
    tbl.push_back(r);
  endtask

  // One clock: inputs held across the rising edge, outputs sampled 1ns after it.
  task automatic step(input logic v, input logic [4:0] idx, input logic [3:0] lbl);
    sel_valid = v; sel_idx = idx; sel_label = lbl;
    @(posedge clk); #1;
    sel_valid = 1'b0; sel_idx = 5'd0; sel_label = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 4'd0);
  endtask

  task automatic do_turn(input logic [4:0] a, input logic [3:0] la,
                         input logic [4:0] b, input logic [3:0] lb, input logic exp_m);
    step(1'b1, a, la);
    step(1'b1, b, lb);
    idle(3);
    chk("turn_hold", {30'd0, match_p, miss_p}, 32'd0);
    idle(1);
    chk($sformatf("turn_%0d_%0d", a, b), {30'd0, match_p, miss_p}, {30'd0, exp_m, ~exp_m});
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; sel_valid = 1'b0; sel_idx = 5'd0; sel_label = 4'd0;
    // v idx lbl | par_mask player s0 s1 match miss
    add(1'b1, 5'd3,  4'd5, 16'h0008, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd9,  4'd5, 16'h0208, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd1,  4'd2, 16'h020A, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd4,  4'd7, 16'h021A, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h021A, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h021A, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h021A, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1);
    add(1'b0, 5'd0,  4'd0, 16'h0208, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd3,  4'd5, 16'h0208, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // matched tile
    add(1'b1, 5'd16, 4'd0, 16'h0208, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // out of range
    add(1'b0, 5'd6,  4'd3, 16'h0208, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // no strobe
    add(1'b1, 5'd0,  4'd1, 16'h0209, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd0,  4'd1, 16'h0209, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // repick first
    add(1'b1, 5'd3,  4'd5, 16'h0209, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // matched, in WAIT2
    add(1'b1, 5'd2,  4'd1, 16'h020D, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 5'd5,  4'd1, 16'h020D, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); // during SHOW
    add(1'b0, 5'd0,  4'd0, 16'h020D, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h020D, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h020D, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 5'd0,  4'd0, 16'h020D, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);

    #12;
    chk("reset_state", status(), 32'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].idx, tbl[i].lbl);
      chk($sformatf("row%0d", i), status(),
          mkst(tbl[i].par, tbl[i].pl, tbl[i].s0, tbl[i].s1, tbl[i].m, tbl[i].ms, 1'b0, 1'b0, 2'b00));
    end

    // Reset asserted mid-SHOW clears everything without waiting for a clock edge.
    step(1'b1, 5'd6, 4'd3);
    step(1'b1, 5'd7, 4'd3);
    idle(2);
    chk("pre_reset", status(), mkst(16'h02CD, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    #2 rst = 1'b0;
    #1 chk("async_reset", status(), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    idle(6);
    chk("aborted_turn", status(), 32'd0);

    // Full game, player 0 wins 5-3.
    do_turn(5'd0, 4'd0, 5'd1, 4'd0, 1'b1);
    do_turn(5'd2, 4'd1, 5'd3, 4'd1, 1'b1);
    do_turn(5'd4, 4'd2, 5'd5, 4'd2, 1'b1);
    do_turn(5'd6, 4'd3, 5'd7, 4'd3, 1'b1);
    do_turn(5'd8, 4'd4, 5'd9, 4'd4, 1'b1);
    do_turn(5'd10, 4'd5, 5'd12, 4'd6, 1'b0);
    do_turn(5'd10, 4'd5, 5'd11, 4'd5, 1'b1);
    do_turn(5'd12, 4'd6, 5'd13, 4'd6, 1'b1);
    chk("mid_game", status(), mkst(16'h3FFF, 1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    do_turn(5'd14, 4'd7, 5'd15, 4'd7, 1'b1);
    chk("p0_wins", status(), mkst(16'hFFFF, 1'b1, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01));
    step(1'b1, 5'd0, 4'd0);
    step(1'b1, 5'd5, 4'd2);
    idle(5);
    chk("done_hold", status(), mkst(16'hFFFF, 1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));

    // Tie game 4-4.
    do_reset();
    chk("reset_again", status(), 32'd0);
    do_turn(5'd0, 4'd0, 5'd1, 4'd0, 1'b1);
    do_turn(5'd2, 4'd1, 5'd3, 4'd1, 1'b1);
    do_turn(5'd4, 4'd2, 5'd5, 4'd2, 1'b1);
    do_turn(5'd6, 4'd3, 5'd7, 4'd3, 1'b1);
    do_turn(5'd8, 4'd4, 5'd10, 4'd5, 1'b0);
    do_turn(5'd8, 4'd4, 5'd9, 4'd4, 1'b1);
    do_turn(5'd10, 4'd5, 5'd11, 4'd5, 1'b1);
    do_turn(5'd12, 4'd6, 5'd13, 4'd6, 1'b1);
    do_turn(5'd14, 4'd7, 5'd15, 4'd7, 1'b1);
    chk("tie", status(), mkst(16'hFFFF, 1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11));

    do_reset();
    step(1'b1, 5'd0, 4'd1);
`ifdef TURN_TIMEOUT_EN
    idle(19);
    chk("pre_timeout", status(), mkst(16'h0001, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    idle(1);
    chk("timeout", status(), mkst(16'h0000, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    idle(1);
    chk("post_timeout", status(), mkst(16'h0000, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
`else
    idle(25);
    chk("no_timeout", status(), mkst(16'h0001, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
